// File: rtl/addition_pkg.sv
// Shared ALU definitions: datapath width, operand type and flag bundle bit ordering.
package addition_pkg;

  localparam int unsigned ALU_WIDTH = 4;

  typedef logic [ALU_WIDTH-1:0] operand_t;

  // Flag bundle layout {carry, overflow, zero}, shared with subtraction and compare.
  localparam int unsigned FLAG_W        = 3;
  localparam int unsigned FLAG_CARRY    = 2;
  localparam int unsigned FLAG_OVERFLOW = 1;
  localparam int unsigned FLAG_ZERO     = 0;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell used to build the ripple-carry core.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/addition.sv
// Registered ripple-carry adder with carry/overflow/zero flags and a valid strobe.
module addition
  import addition_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH:0]      carry;
  logic [WIDTH-1:0]    sum_d;
  logic [FLAG_W-1:0]   flags_d;
  logic [WIDTH-1:0]    sum_q;
  logic [FLAG_W-1:0]   flags_q;
  logic                valid_q;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (carry[i]),
      .s    (sum_d[i]),
      .cout (carry[i+1])
    );
  end

  always_comb begin
    flags_d                = '0;
    flags_d[FLAG_CARRY]    = carry[WIDTH];
    // Signed overflow: like-signed operands producing a result of the other sign.
    flags_d[FLAG_OVERFLOW] = (A[WIDTH-1] == B[WIDTH-1]) && (sum_d[WIDTH-1] != A[WIDTH-1]);
    flags_d[FLAG_ZERO]     = (sum_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q   <= sum_d;
        flags_q <= flags_d;
      end
    end
  end

  assign Sum       = sum_q;
  assign carry_out = flags_q[FLAG_CARRY];
  assign overflow  = flags_q[FLAG_OVERFLOW];
  assign zero      = flags_q[FLAG_ZERO];
  assign out_valid = valid_q;

endmodule

// File: tb/tb_addition.sv
// Directed and exhaustive self-checking bench for the registered adder.
module tb_addition;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       carry_in;
  logic       in_valid;
  logic [3:0] Sum;
  logic       carry_out;
  logic       overflow;
  logic       zero;
  logic       out_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  addition #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .carry_in  (carry_in),
    .in_valid  (in_valid),
    .Sum       (Sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid)
  );

  // Directed vectors: {A, B, carry_in} -> {Sum, carry_out, overflow, zero}
  logic [3:0] va  [6] = '{4'b0001, 4'b1111, 4'b1010, 4'b1000, 4'b0000, 4'b0111};
  logic [3:0] vb  [6] = '{4'b0010, 4'b0001, 4'b0101, 4'b1000, 4'b0000, 4'b0001};
  logic       vc  [6] = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b1,    1'b0};
  logic [3:0] es  [6] = '{4'b0011, 4'b0000, 4'b1111, 4'b0001, 4'b0001, 4'b1000};
  logic       eco [6] = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b0};
  logic       eov [6] = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1};
  logic       ez  [6] = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b0,    1'b0};

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic v);
    A = a; B = b; carry_in = ci; in_valid = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1, 1'b1);
    @(posedge clk); #1;
    tests++;
    if ({Sum, carry_out, overflow, zero, out_valid} !== 8'b0) begin
      fails++;
      $display("FAIL reset_state: got Sum=%b co=%b ov=%b z=%b ov_valid=%b, want all 0",
               Sum, carry_out, overflow, zero, out_valid);
    end
    rst = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  // Each vector alone; inputs change right after the edge so a zero-latency path would show.
  task automatic test_vectors();
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vc[i], 1'b1);
      @(posedge clk); #1;
      drive(~va[i], vb[i], ~vc[i], 1'b0);
      tests++;
      if ({Sum, carry_out, overflow, zero, out_valid} !==
          {es[i], eco[i], eov[i], ez[i], 1'b1}) begin
        fails++;
        $display("FAIL vector_%0d: got Sum=%b co=%b ov=%b z=%b v=%b, want Sum=%b co=%b ov=%b z=%b v=1",
                 i, Sum, carry_out, overflow, zero, out_valid, es[i], eco[i], eov[i], ez[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vc[i], 1'b1);
      @(posedge clk); #1;
      tests++;
      if ({Sum, carry_out, overflow, zero, out_valid} !==
          {es[i], eco[i], eov[i], ez[i], 1'b1}) begin
        fails++;
        $display("FAIL b2b_%0d: got Sum=%b co=%b ov=%b z=%b v=%b, want Sum=%b co=%b ov=%b z=%b v=1",
                 i, Sum, carry_out, overflow, zero, out_valid, es[i], eco[i], eov[i], ez[i]);
      end
    end
  endtask

  // Follows test_back_to_back: last captured result is 0111+0001 -> 1000, ov=1.
  task automatic test_hold();
    drive(4'b0011, 4'b0011, 1'b0, 1'b0);
    @(posedge clk); #1;
    tests++;
    if ({Sum, carry_out, overflow, zero, out_valid} !== {4'b1000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL hold: got Sum=%b co=%b ov=%b z=%b v=%b, want Sum=1000 co=0 ov=1 z=0 v=0",
               Sum, carry_out, overflow, zero, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    drive(4'b0001, 4'b0010, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(4'b0111, 4'b0001, 1'b0, 1'b1);
    tests++;
    if ({Sum, carry_out, overflow, zero, out_valid} !== 8'b0) begin
      fails++;
      $display("FAIL reset_midstream: got Sum=%b co=%b ov=%b z=%b v=%b, want all 0",
               Sum, carry_out, overflow, zero, out_valid);
    end
    @(posedge clk); #1;
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    tests++;
    if ({Sum, carry_out, overflow, zero, out_valid} !== {4'b1000, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL after_reset: got Sum=%b co=%b ov=%b z=%b v=%b, want Sum=1000 co=0 ov=1 z=0 v=1",
               Sum, carry_out, overflow, zero, out_valid);
    end
  endtask

  task automatic test_sweep();
    logic [3:0] a, b;
    logic       ci;
    logic [4:0] full;
    logic       exp_ov;
    for (int i = 0; i < 512; i++) begin
      a  = i[3:0];
      b  = i[7:4];
      ci = i[8];
      full = {1'b0, a} + {1'b0, b} + {4'b0, ci};
      exp_ov = (a[3] == b[3]) && (full[3] != a[3]);
      drive(a, b, ci, 1'b1);
      @(posedge clk); #1;
      tests++;
      if ({Sum, carry_out, overflow, zero, out_valid} !==
          {full[3:0], full[4], exp_ov, full[3:0] == 4'b0, 1'b1}) begin
        fails++;
        $display("FAIL sweep a=%b b=%b ci=%b: got Sum=%b co=%b ov=%b z=%b v=%b, want Sum=%b co=%b ov=%b z=%b v=1",
                 a, b, ci, Sum, carry_out, overflow, zero, out_valid,
                 full[3:0], full[4], exp_ov, full[3:0] == 4'b0);
      end
    end
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_hold();
    test_reset_midstream();
    test_sweep();
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addition.md
Name: addition

Overview:
- Registered WIDTH-bit binary adder with carry-in and carry-out; the arithmetic step of the ALU datapath.
- Combinational ripple-carry core built from single-bit full-adder cells.
- Result, carry and status flags are captured in output registers, giving one cycle of latency.
- A valid strobe travels alongside the data so the ALU controller can qualify results.

Parameters:
- WIDTH, 4, operand and sum width in bits (must be >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B, unsigned or two's complement.
- carry_in  input  1  carry into bit 0.
- in_valid  input  1  operands valid this cycle; capture the result.
- Sum  output  WIDTH  registered (A + B + carry_in) mod 2^WIDTH.
- carry_out  output  1  registered unsigned carry out of the MSB.
- overflow  output  1  registered signed overflow flag.
- zero  output  1  registered flag, 1 when Sum is all zeros.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. Every register takes its reset value on a clk rising edge where rst=1.
- Reset values: Sum=0, carry_out=0, overflow=0, zero=0, out_valid=0.
- rst has priority over in_valid. Asserting reset mid-stream discards any in-flight result: out_valid=0 on the following cycle.
- Core: WIDTH full-adder cells chained from bit 0 to bit WIDTH-1.
  - The carry into cell 0 is carry_in.
  - The carry out of cell WIDTH-1 is the raw carry.
  - The core is purely combinational and has no feedback.
- Full-add equation (full_adder cell):
  - s = a ^ b ^ cin
  - cout = (a & b) | (a & cin) | (b & cin)
- Arithmetic: {carry_out, Sum} = A + B + carry_in, computed WIDTH+1 bits wide, with no saturation.
- overflow = (A[MSB] == B[MSB]) && (Sum[MSB] != A[MSB]), evaluated on the pre-register sum.
- zero = (pre-register sum == 0). It is independent of carry_out, so 1111+0001 gives zero=1 and carry_out=1.
- Latency:
  - If in_valid=1 at edge N (and rst=0), the results for those operands appear on Sum, carry_out, overflow and zero after edge N, with out_valid=1, during cycle N+1.
  - If in_valid=0 at an edge, Sum, carry_out, overflow and zero hold their previous values and out_valid goes to 0.
- Back-to-back: in_valid may be high every cycle. Throughput is one result per cycle with no stalls and no backpressure.
- Wrap-around: all-ones + 1 gives Sum=0 and carry_out=1. Maximum input (all ones + all ones + 1) gives Sum=all ones and carry_out=1.
- Inputs are sampled only at the clk edge. Glitches between edges have no effect.
- No X-propagation requirements beyond standard RTL semantics. Inputs are assumed driven whenever in_valid=1.

Decomposition:
- Shared ALU package:
  - ALU_WIDTH constant, default 4; addition's WIDTH defaults from it.
  - A typedef for a WIDTH-bit operand.
  - A struct-free flag bundle {carry, overflow, zero} ordering constant, for reuse by the subtraction and compare blocks.
- One sub-module, full_adder, with ports a, b, cin, s, cout. It is instantiated WIDTH times in a generate loop.
- Flag logic and output registers live in addition itself.

Test Plan (WIDTH=4; each vector driven with in_valid=1, checked one cycle later with out_valid=1):
- 1. A=0001, B=0010, carry_in=0 -> Sum=0011, carry_out=0, overflow=0, zero=0.
- 2. A=1111, B=0001, carry_in=0 -> Sum=0000, carry_out=1, overflow=0, zero=1.
- 3. A=1010, B=0101, carry_in=0 -> Sum=1111, carry_out=0, overflow=0, zero=0. Then A=1000, B=1000, carry_in=1 -> Sum=0001, carry_out=1, overflow=1.
- 4. A=0000, B=0000, carry_in=1 -> Sum=0001, carry_out=0. Then A=0111, B=0001, carry_in=0 -> Sum=1000, overflow=1, carry_out=0.
- 5. Back-to-back and hold:
  - Vectors 1-4 on consecutive cycles -> results on consecutive cycles, each exactly one cycle after its input.
  - Then in_valid=0 with new operands -> out_valid=0 and Sum holds the last value.
- 6. Reset:
  - Assert rst together with in_valid=1 (A=1111, B=1111, carry_in=1) -> next cycle all outputs 0, out_valid=0.
  - Release rst -> next valid vector is processed normally.
- Exhaustive sweep of all 512 (A, B, carry_in) combinations against a reference model, checking Sum, carry_out, overflow and zero.
